b02_line_scheduler: RTL and testbench

- Time-shares one b02-style serial-line recognizer (bit input `linea`, registered flag output `u`) between NREQ requesters.
- Each requester offers a 4-bit nibble. The block arbitrates round-robin, clears the recognizer, shifts the nibble MSB-first onto `linea`, samples `u`, and returns a tagged result.
- Sits between the requesters and the recognizer instance; it is the recognizer's only driver.

---
 rtl/b02_line_scheduler.sv | 146 ++++++++++++++
 tb/tb_b02_line_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/b02_line_scheduler.sv
// Round-robin scheduler that time-shares one serial-line recognizer between NREQ requesters.
// Each grant clears the recognizer, shifts a nibble MSB-first, samples u and returns a tagged result.
module b02_line_scheduler #(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int RESP_LAT = 1,
    parameter int CNTW     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              linea,
    output logic              rec_clear,
    input  logic              u,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_match,
    output logic              busy,
    output logic [CNTW-1:0]   match_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] cur_id;
    logic [3:0]     nibble;
    logic [1:0]     bit_idx;
    logic [2:0]     wait_cnt;

    logic            hi_found;
    logic            lo_found;
    logic [IDW-1:0]  hi_idx;
    logic [IDW-1:0]  lo_idx;
    logic            grant_any;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] grant_oh;
    logic [3:0]      grant_nib;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    // Lowest valid index above last_grant wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        hi_found  = 1'b0;
        lo_found  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (IDW'(i) > last_grant) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IDW'(i);
                end
            end
        end
        grant_any = hi_found | lo_found;
        grant_idx = hi_found ? hi_idx : lo_idx;
        grant_oh  = '0;
        grant_nib = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_idx) begin
                grant_oh[i] = grant_any;
                grant_nib   = req_data[4*i +: 4];
            end
        end
    end

    // State names the work done at the coming edge; outputs appear in the cycle after it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            last_grant  <= IDW'(NREQ - 1);
            req_ready   <= '0;
            linea       <= 1'b0;
            rec_clear   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_match   <= 1'b0;
            busy        <= 1'b0;
            match_count <= '0;
            bit_idx     <= '0;
            wait_cnt    <= '0;
        end else begin
            req_ready <= '0;
            linea     <= 1'b0;
            rec_clear <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        req_ready  <= grant_oh;
                        nibble     <= grant_nib;
                        cur_id     <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= S_CLR;
                    end
                end
                S_CLR: begin
                    rec_clear <= 1'b1;
                    bit_idx   <= 2'd3;
                    state     <= S_SHIFT;
                end
                S_SHIFT: begin
                    linea   <= nibble[bit_idx];
                    bit_idx <= bit_idx - 2'd1;
                    if (bit_idx == 2'd0) begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 3'(RESP_LAT - 1)) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= cur_id;
                    rsp_match <= u;
                    if (u) begin
                        match_count <= sat_inc(match_count);
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_b02_line_scheduler.sv
// Bench for b02_line_scheduler: table-driven transactions, directed corner sequences,
// a randomized run against a transaction-level timing model, and a small-counter instance.
module tb_b02_line_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        linea, rec_clear, u = 1'b0;
    logic        rsp_valid, rsp_match, busy;
    logic [1:0]  rsp_id;
    logic [7:0]  match_count;

    logic        b_reset = 1'b1;
    logic [2:0]  b_req_valid = '0;
    logic [11:0] b_req_data = '0;
    logic [2:0]  b_req_ready;
    logic        b_linea, b_rec_clear, b_u = 1'b0;
    logic        b_rsp_valid, b_rsp_match, b_busy;
    logic [1:0]  b_rsp_id;
    logic [1:0]  b_match_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    b02_line_scheduler #(.NREQ(4), .IDW(2), .RESP_LAT(1), .CNTW(8)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .linea(linea), .rec_clear(rec_clear), .u(u),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_match(rsp_match),
        .busy(busy), .match_count(match_count)
    );

    b02_line_scheduler #(.NREQ(3), .IDW(2), .RESP_LAT(3), .CNTW(2)) dut_b (
        .clock(clock), .reset(b_reset), .req_valid(b_req_valid), .req_data(b_req_data),
        .req_ready(b_req_ready), .linea(b_linea), .rec_clear(b_rec_clear), .u(b_u),
        .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_match(b_rsp_match),
        .busy(b_busy), .match_count(b_match_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  v;
        logic [15:0] d;
        logic        uval;
        int          id;
        logic [3:0]  nib;
        int          cnt;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] a_vec();
        return {13'd0, req_ready, linea, rec_clear, rsp_valid, rsp_id, rsp_match, busy, match_count};
    endfunction

    function automatic int pick(input int lg, input logic [3:0] v);
        int c;
        for (int k = 1; k <= 4; k++) begin
            c = (lg + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        u = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_accept(output int w);
        w = 0;
        do begin
            tick();
            w++;
        end while (req_ready == 4'd0 && w < 20);
    endtask

    // One full transaction on the 4-requester instance, checked cycle by cycle from accept.
    task automatic run_txn(input logic [3:0] v, input logic [15:0] d, input logic uval,
                           input int exp_id, input logic [3:0] exp_nib, input int exp_cnt);
        int w;
        req_valid = v;
        req_data = d;
        u = ~uval;
        wait_accept(w);
        check("accept", {28'd0, req_ready}, 32'(1) << exp_id);
        check("accept_busy", {31'd0, busy}, 32'd0);
        req_valid = '0;
        req_data = ~d;
        tick();
        check("clear", {29'd0, rec_clear, linea, busy}, 32'b101);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("shift_bit", {29'd0, rec_clear, linea, rsp_valid}, {29'd0, 1'b0, exp_nib[3-k], 1'b0});
        end
        tick();
        check("wait", {29'd0, linea, rsp_valid, busy}, 32'b001);
        u = uval;
        tick();
        check("resp", {27'd0, rsp_valid, rsp_id, rsp_match, busy}, {27'd0, 1'b1, 2'(exp_id), uval, 1'b1});
        check("resp_count", {24'd0, match_count}, 32'(exp_cnt));
        u = ~uval;
        tick();
        check("after_resp", {28'd0, rsp_valid, busy, rsp_id, rsp_match} , {27'd0, 2'b00, 2'(exp_id), uval});
    endtask

    initial begin
        int w, prev, lg, t0, tid, cnt, lid, g, d;
        logic lm, active;
        logic [3:0] tnib;
        int free_at;
        logic [31:0] exp_v;

        tbl[0] = '{4'b0001, 16'h0009, 1'b1, 0, 4'h9, 1};
        tbl[1] = '{4'b1111, 16'hA5C3, 1'b0, 1, 4'hC, 1};
        tbl[2] = '{4'b0100, 16'h0600, 1'b1, 2, 4'h6, 2};
        tbl[3] = '{4'b0101, 16'h0E0B, 1'b1, 0, 4'hB, 3};
        tbl[4] = '{4'b0101, 16'h0E0B, 1'b0, 2, 4'hE, 3};
        tbl[5] = '{4'b1000, 16'h7000, 1'b1, 3, 4'h7, 4};
        tbl[6] = '{4'b0011, 16'h00F4, 1'b0, 0, 4'h4, 4};
        tbl[7] = '{4'b0110, 16'h0D20, 1'b1, 1, 4'h2, 5};

        tick();
        tick();
        check("reset_state", a_vec(), 32'd0);
        check("b_reset_state", {26'd0, b_req_ready, b_linea, b_rec_clear, b_rsp_valid, b_busy},
              32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].v, tbl[i].d, tbl[i].uval, tbl[i].id, tbl[i].nib, tbl[i].cnt);
        end

        // All four requesters held pending: strict rotation at the minimum spacing.
        do_reset();
        req_valid = 4'hF;
        req_data = 16'h9C36;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_accept(w);
            check("rr_grant", {28'd0, req_ready}, 32'(1) << (k % 4));
            if (k > 0) check("rr_spacing", 32'(cyc - prev), 32'd8);
            prev = cyc;
            tick();
        end
        req_valid = '0;
        repeat (10) tick();

        // Reset in the middle of shifting aborts the transaction and the arbitration pointer.
        run_txn(4'b0001, 16'h000C, 1'b1, 0, 4'hC, 1);
        req_valid = 4'b0001;
        req_data = 16'h000B;
        u = 1'b0;
        wait_accept(w);
        check("mid_accept", {28'd0, req_ready}, 32'b0001);
        req_valid = '0;
        tick();
        tick();
        check("mid_bit3", {31'd0, linea}, 32'd1);
        tick();
        check("mid_bit2", {30'd0, linea, busy}, 32'b01);
        reset = 1'b1;
        tick();
        check("mid_reset_outputs", a_vec(), 32'd0);
        reset = 1'b0;
        run_txn(4'b0011, 16'h00D7, 1'b1, 0, 4'h7, 1);

        // Randomized requesters, u and occasional resets against a transaction timing model.
        reset = 1'b1;
        req_valid = '0;
        tick();
        active = 1'b0; lg = 3; cnt = 0; lid = 0; lm = 1'b0; free_at = 0; t0 = 0; tid = 0; tnib = '0;
        for (int n = 0; n < 1500; n++) begin
            exp_v = '0;
            if (reset) begin
                active = 1'b0; lg = 3; cnt = 0; lid = 0; lm = 1'b0; free_at = n + 1;
            end else begin
                if (active && n == t0 + 7) begin
                    exp_v[11] = 1'b1;
                    exp_v[9] = 1'b1;
                    lid = tid;
                    lm = u;
                    if (u && cnt < 255) cnt++;
                    active = 1'b0;
                end
                if (n >= free_at && req_valid != 4'd0) begin
                    g = pick(lg, req_valid);
                    exp_v[18:15] = 4'(1 << g);
                    active = 1'b1; t0 = n; tid = g; lg = g; free_at = n + 8;
                    tnib = 4'(req_data >> (4 * g));
                end
                if (active) begin
                    d = n - t0;
                    exp_v[13] = (d == 1);
                    exp_v[14] = (d >= 2 && d <= 5) ? tnib[5-d] : 1'b0;
                    exp_v[9] = (d >= 1);
                end
            end
            exp_v[12] = 1'b0;
            exp_v[10] = (lm === 1'b1);
            exp_v[8] = 1'b0;
            exp_v[7:0] = 8'(cnt);
            exp_v[12:11] = {lid[1], exp_v[11]};
            exp_v = {13'd0, exp_v[18:15], exp_v[14:13], exp_v[11], 2'(lid), lm, exp_v[9], 8'(cnt)};
            check("rand", a_vec(), exp_v);
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) begin
                    req_valid[i] = 1'b0;
                    req_data[4*i +: 4] = 4'($urandom);
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[4*i +: 4] = 4'($urandom);
                end
            end
            u = 1'($urandom);
            reset = ($urandom_range(0, 63) == 0);
            tick();
        end
        reset = 1'b0;
        req_valid = '0;

        // Three requesters, RESP_LAT=3, 2-bit saturating counter.
        b_reset = 1'b0;
        b_req_valid = 3'b111;
        b_req_data = 12'h5A3;
        b_u = 1'b0;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            do begin
                tick();
                w++;
            end while (b_req_ready == 3'd0 && w < 30);
            check("b_grant", {29'd0, b_req_ready}, 32'(1) << (k % 3));
            if (k > 0) check("b_spacing", 32'(cyc - prev), 32'd10);
            prev = cyc;
            tnib = 4'(b_req_data >> (4 * (k % 3)));
            tick();
            check("b_clear", {29'd0, b_rec_clear, b_linea, b_busy}, 32'b101);
            for (int j = 0; j < 4; j++) begin
                tick();
                check("b_bit", {31'd0, b_linea}, {31'd0, tnib[3-j]});
            end
            for (int j = 0; j < 3; j++) begin
                tick();
                check("b_wait", {29'd0, b_linea, b_rsp_valid, b_busy}, 32'b001);
            end
            b_u = 1'b1;
            tick();
            check("b_resp", {28'd0, b_rsp_valid, b_rsp_id, b_rsp_match}, {28'd0, 1'b1, 2'(k % 3), 1'b1});
            check("b_count", {30'd0, b_match_count}, (k < 3) ? 32'(k + 1) : 32'd3);
            b_u = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
